triangle_broadcaster: RTL and testbench

- Sits directly upstream of the raster core array and feeds every core in parallel.
- Accepts 10-word triangle records from the setup stage over a valid/ready stream and buffers them in two ping-pong record buffers.
- Broadcasts each record on a shared is_handshake/data bus, only once every core reports ready.
- After the frame's last triangle, injects an end-triangle record that moves all cores to writeback, then pulses frame_done.

---
 rtl/triangle_broadcaster_if.sv | 36 +++
 rtl/triangle_broadcaster.sv | 211 +++++++++++++++++++++
 tb/tb_triangle_broadcaster.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_broadcaster_if.sv
// Stream and broadcast bundle for the triangle broadcaster.
// slave: the broadcaster's view (consumes the setup stream, drives the core bus).
// master: the environment's view (setup stage driver plus core-bus observer).
interface triangle_broadcaster_if #(
  parameter int unsigned LWIDTH = 32
) ();

  // Setup-stage record stream
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;

  // Shared broadcast bus to the raster cores
  logic              bc_handshake;
  logic [LWIDTH-1:0] bc_data;

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready,
    output bc_handshake,
    output bc_data
  );

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready,
    input  bc_handshake,
    input  bc_data
  );

endinterface

// File: rtl/triangle_broadcaster.sv
// Triangle broadcaster: buffers setup-stage triangle records in two ping-pong
// buffers and broadcasts each one to every raster core once all cores are idle.
// After a frame's last triangle an end-triangle record is injected, followed by
// a one-cycle frame_done pulse.
module triangle_broadcaster #(
  parameter int unsigned NUM_CORES   = 64,
  parameter int unsigned LWIDTH      = 32,
  parameter int unsigned REC_WORDS   = 10,
  parameter int unsigned READY_GUARD = 1,
  parameter logic [31:0] END_HEADER  = 32'h0000_0FFF
) (
  input  logic                   clk,
  input  logic                   nreset,
  triangle_broadcaster_if.slave  bus,
  input  logic [NUM_CORES-1:0]   cores_ready,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned IdxW = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;
  localparam int unsigned GrdW = (READY_GUARD > 1) ? $clog2(READY_GUARD + 1) : 1;

  localparam logic [IdxW-1:0] FirstIdx = '0;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(REC_WORDS - 1);
  localparam logic [IdxW-1:0] OneIdx   = IdxW'(1);
  localparam logic [GrdW-1:0] GuardEnd = GrdW'(READY_GUARD - 1);
  localparam logic [GrdW-1:0] OneGrd   = GrdW'(1);

  // Output FSM encoding
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
  localparam logic [1:0] StGuard   = 2'd2;
  localparam logic [1:0] StSendEnd = 2'd3;

  // Record storage: two ping-pong buffers of REC_WORDS words
  logic [31:0] rec_buf_q [2][REC_WORDS];

  // Input-side state
  logic            wr_sel_q, wr_sel_d;
  logic [IdxW-1:0] wr_it_q, wr_it_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      full_q, full_d;
  logic [1:0]      full_set, full_clr;

  // Output-side state
  logic [1:0]      state_q, state_d;
  logic            rd_sel_q, rd_sel_d;
  logic [IdxW-1:0] rd_it_q, rd_it_d;
  logic [GrdW-1:0] guard_cnt_q, guard_cnt_d;
  logic            pending_end_q, pending_end_d;

  // Registered outputs
  logic              s_ready_q, s_ready_d;
  logic              bc_handshake_q, bc_handshake_d;
  logic [LWIDTH-1:0] bc_data_q, bc_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic accept;
  logic all_ready;

  assign accept    = bus.s_valid && s_ready_q;
  assign all_ready = &cores_ready;

  // Input side: fill the write buffer word by word, hand it over when complete
  always_comb begin
    wr_it_d  = wr_it_q;
    wr_sel_d = wr_sel_q;
    last_d   = last_q;
    full_set = 2'b00;
    if (accept) begin
      if (wr_it_q == LastIdx) begin
        wr_it_d          = FirstIdx;
        wr_sel_d         = ~wr_sel_q;
        full_set[wr_sel_q] = 1'b1;
        // s_last only matters on the record's final word
        last_d[wr_sel_q] = bus.s_last;
      end else begin
        wr_it_d = wr_it_q + OneIdx;
      end
    end
  end

  // Output FSM: wait for all cores, stream a record, then hold off for the guard
  always_comb begin
    state_d        = state_q;
    rd_sel_d       = rd_sel_q;
    rd_it_d        = rd_it_q;
    guard_cnt_d    = guard_cnt_q;
    pending_end_d  = pending_end_q;
    full_clr       = 2'b00;
    bc_handshake_d = 1'b0;
    bc_data_d      = bc_data_q;
    frame_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A pending end record goes out before any buffered next-frame record
        if (pending_end_q && all_ready) begin
          state_d        = StSendEnd;
          rd_it_d        = FirstIdx;
          bc_handshake_d = 1'b1;
          bc_data_d      = LWIDTH'(END_HEADER);
        end else if (full_q[rd_sel_q] && all_ready) begin
          state_d        = StSend;
          rd_it_d        = FirstIdx;
          bc_handshake_d = 1'b1;
          bc_data_d      = LWIDTH'(rec_buf_q[rd_sel_q][FirstIdx]);
        end
      end

      StSend: begin
        // rd_it_q is the word currently on the bus; cores_ready is ignored here
        if (rd_it_q == LastIdx) begin
          full_clr[rd_sel_q] = 1'b1;
          rd_sel_d           = ~rd_sel_q;
          pending_end_d      = last_q[rd_sel_q];
          state_d            = StGuard;
          guard_cnt_d        = '0;
        end else begin
          rd_it_d        = rd_it_q + OneIdx;
          bc_handshake_d = 1'b1;
          bc_data_d      = LWIDTH'(rec_buf_q[rd_sel_q][rd_it_d]);
        end
      end

      StSendEnd: begin
        if (rd_it_q == LastIdx) begin
          pending_end_d = 1'b0;
          frame_done_d  = 1'b1;
          state_d       = StGuard;
          guard_cnt_d   = '0;
        end else begin
          rd_it_d        = rd_it_q + OneIdx;
          bc_handshake_d = 1'b1;
          bc_data_d      = '0;
        end
      end

      StGuard: begin
        // Cores drop ready one cycle after consuming; don't trust it before then
        if (guard_cnt_q == GuardEnd) begin
          state_d = StIdle;
        end else begin
          guard_cnt_d = guard_cnt_q + OneGrd;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Buffer occupancy and registered status outputs derived from next state
  always_comb begin
    // Set and clear always target different buffers, so both can apply at once
    full_d    = (full_q & ~full_clr) | full_set;
    s_ready_d = ~full_d[wr_sel_d];
    busy_d    = (|full_d) || pending_end_d || (state_d != StIdle);
  end

  // Control and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_sel_q       <= 1'b0;
      wr_it_q        <= '0;
      last_q         <= 2'b00;
      full_q         <= 2'b00;
      state_q        <= StIdle;
      rd_sel_q       <= 1'b0;
      rd_it_q        <= '0;
      guard_cnt_q    <= '0;
      pending_end_q  <= 1'b0;
      s_ready_q      <= 1'b0;
      bc_handshake_q <= 1'b0;
      bc_data_q      <= '0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      wr_sel_q       <= wr_sel_d;
      wr_it_q        <= wr_it_d;
      last_q         <= last_d;
      full_q         <= full_d;
      state_q        <= state_d;
      rd_sel_q       <= rd_sel_d;
      rd_it_q        <= rd_it_d;
      guard_cnt_q    <= guard_cnt_d;
      pending_end_q  <= pending_end_d;
      s_ready_q      <= s_ready_d;
      bc_handshake_q <= bc_handshake_d;
      bc_data_q      <= bc_data_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
    end
  end

  // Record storage write; contents are qualified by full_q so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      rec_buf_q[wr_sel_q][wr_it_q] <= bus.s_data;
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.bc_handshake = bc_handshake_q;
  assign bus.bc_data      = bc_data_q;
  assign frame_done       = frame_done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_triangle_broadcaster.sv
// Self-checking bench for triangle_broadcaster: directed scenarios plus a
// randomized phase, all checked against a record-level scoreboard of the
// expected broadcast word sequence.
module tb_triangle_broadcaster;

  localparam int unsigned NUM_CORES   = 64;
  localparam int unsigned LWIDTH      = 32;
  localparam int unsigned REC_WORDS   = 10;
  localparam int unsigned READY_GUARD = 1;
  localparam logic [31:0] END_HEADER  = 32'h0000_0FFF;

  logic                 clk = 1'b0;
  logic                 nreset = 1'b0;
  logic [NUM_CORES-1:0] cores_ready = '1;
  logic                 frame_done;
  logic                 busy;

  triangle_broadcaster_if #(.LWIDTH(LWIDTH)) bus ();

  triangle_broadcaster #(
    .NUM_CORES  (NUM_CORES),
    .LWIDTH     (LWIDTH),
    .REC_WORDS  (REC_WORDS),
    .READY_GUARD(READY_GUARD),
    .END_HEADER (END_HEADER)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus        (bus.slave),
    .cores_ready(cores_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wrap_up();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  // Scoreboard: expected broadcast words in order, flag marks an end record's final word
  logic [31:0] exp_q[$];
  bit          fin_q[$];

  bit          mon_en = 1'b0;
  bit          exp_fd = 1'b0;
  bit          prev_hs = 1'b0;
  bit          prev_all_ready = 1'b0;
  int          run_len = 0;
  int          gap_len = 1000;
  int          last_gap = 0;
  int          last_rise_cyc = 0;
  int          bursts = 0;
  int          hs_seen = 0;
  int          fd_count = 0;
  logic [31:0] last_word = '0;

  task automatic mon_reset();
    exp_q.delete();
    fin_q.delete();
    exp_fd  = 1'b0;
    gap_len = 1000;
    run_len = 0;
  endtask

  // Bus monitor, sampling away from the active edge
  always @(negedge clk) begin
    bit fd_next;
    fd_next = 1'b0;
    if (mon_en) begin
      if (bus.bc_handshake) begin
        if (!prev_hs) begin
          check("ready_gate", prev_all_ready, 1);
          if (gap_len < 1000) check("guard_gap", gap_len >= READY_GUARD, 1);
          last_gap      = gap_len;
          last_rise_cyc = cyc;
          run_len       = 0;
        end
        run_len++;
        hs_seen++;
        if (exp_q.size() == 0) begin
          check("bc_unexpected", 64'(exp_q.size()), 1);
        end else begin
          check("bc_word", bus.bc_data, exp_q.pop_front());
          fd_next = fin_q.pop_front();
        end
        last_word = bus.bc_data;
      end else begin
        if (prev_hs) begin
          check("burst_len", run_len, REC_WORDS);
          check("bc_hold", bus.bc_data, last_word);
          gap_len = 0;
          bursts++;
        end
        if (gap_len < 1000) gap_len++;
      end
      if (frame_done || exp_fd) check("frame_done", frame_done, exp_fd);
      if (frame_done) fd_count++;
      exp_fd = fd_next;
    end
    prev_hs        = bus.bc_handshake;
    prev_all_ready = &cores_ready;
  end

  // Setup-stage driver
  int acc_words = 0;
  int stall_cycles = 0;
  int last_acc_cyc = 0;

  task automatic push_record(input logic [31:0] w[REC_WORDS], input bit last, input int max_gap);
    for (int i = 0; i < REC_WORDS; i++) begin
      int t;
      bit acc;
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          bus.s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w[i];
      bus.s_last  = (i == REC_WORDS - 1) ? last : 1'($urandom_range(1, 0));
      t   = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.s_ready;
        if (!acc) stall_cycles++;
        @(posedge clk);
        #1;
        t++;
        if (!acc && t > 3000) begin
          check("push_timeout", 64'(t), 0);
          wrap_up();
        end
      end
      acc_words++;
    end
    bus.s_valid  = 1'b0;
    last_acc_cyc = cyc;
    for (int i = 0; i < REC_WORDS; i++) begin
      exp_q.push_back(w[i]);
      fin_q.push_back(1'b0);
    end
    if (last) begin
      for (int i = 0; i < REC_WORDS; i++) begin
        exp_q.push_back(i == 0 ? END_HEADER : 32'h0);
        fin_q.push_back(i == REC_WORDS - 1);
      end
    end
  endtask

  task automatic rand_record(output logic [31:0] w[REC_WORDS]);
    for (int i = 0; i < REC_WORDS; i++) w[i] = $urandom;
  endtask

  task automatic wait_bursts(input int target, input string tag);
    int t;
    t = 0;
    while (bursts < target) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 1000) begin
        check(tag, 64'(bursts), 64'(target));
        wrap_up();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Random core-ready disturbance for the randomized phase
  bit rr_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_en) begin
        if ($urandom_range(7, 0) == 0) cores_ready[$urandom_range(NUM_CORES - 1, 0)] = 1'b0;
        else if ($urandom_range(2, 0) == 0) cores_ready = '1;
      end
    end
  end

  logic [31:0] r0[REC_WORDS];
  logic [31:0] r1[REC_WORDS];
  logic [31:0] r2[REC_WORDS];
  int b0, acc0, hs0, st0, fd0, raise_cyc, t;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    nreset      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_bc_handshake", bus.bc_handshake, 0);
    check("rst_bc_data", bus.bc_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s_ready_after_rst", bus.s_ready, 1);
    check("busy_after_rst", busy, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single record, fixed contents, all cores ready
    r0[0] = 32'h0000_0040;
    for (int i = 1; i < REC_WORDS; i++) r0[i] = 32'h11 * i;
    hs0 = hs_seen;
    b0  = bursts;
    push_record(r0, 1'b0, 0);
    wait_bursts(b0 + 1, "single_timeout");
    check("single_latency", 64'(last_rise_cyc + 1 - last_acc_cyc), 2);
    check("single_len", 64'(hs_seen - hs0), REC_WORDS);

    // Ready gating on a single core
    cores_ready[5] = 1'b0;
    rand_record(r1);
    hs0 = hs_seen;
    b0  = bursts;
    push_record(r1, 1'b0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("gated_no_bc", 64'(hs_seen - hs0), 0);
    check("gated_busy", busy, 1);
    @(posedge clk);
    #1;
    cores_ready[5] = 1'b1;
    raise_cyc      = cyc;
    wait_bursts(b0 + 1, "gated_timeout");
    check("gated_start", 64'(last_rise_cyc - raise_cyc), 1);

    // Back-pressure: three records with every core busy
    cores_ready = '0;
    rand_record(r0);
    rand_record(r1);
    rand_record(r2);
    acc0 = acc_words;
    b0   = bursts;
    fork
      begin
        push_record(r0, 1'b0, 0);
        push_record(r1, 1'b0, 0);
        push_record(r2, 1'b0, 0);
      end
    join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp_accepted", 64'(acc_words - acc0), 2 * REC_WORDS);
    check("bp_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    cores_ready = '1;
    wait_bursts(b0 + 3, "bp_timeout");
    check("bp_total", 64'(acc_words - acc0), 3 * REC_WORDS);

    // End of frame: second record carries s_last
    rand_record(r0);
    rand_record(r1);
    fd0 = fd_count;
    b0  = bursts;
    push_record(r0, 1'b0, 0);
    push_record(r1, 1'b1, 0);
    t = 0;
    while (fd_count == fd0) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 500) begin
        check("eof_timeout", 64'(fd_count), 64'(fd0 + 1));
        wrap_up();
      end
    end
    check("eof_bursts", 64'(bursts - b0), 3);
    check("eof_busy_at_done", busy, 1);
    @(negedge clk);
    #1;
    check("eof_busy_after", busy, 0);
    check("eof_done_once", frame_done, 0);

    // Overlap: second record streams in while the first broadcasts
    @(posedge clk);
    #1;
    rand_record(r0);
    rand_record(r1);
    st0 = stall_cycles;
    b0  = bursts;
    push_record(r0, 1'b0, 0);
    push_record(r1, 1'b0, 0);
    check("ovl_no_stall", 64'(stall_cycles - st0), 0);
    wait_bursts(b0 + 2, "ovl_timeout");
    check("ovl_gap", 64'(last_gap), READY_GUARD + 1);

    // Reset in the middle of a broadcast (word 4 on the bus)
    rand_record(r0);
    push_record(r0, 1'b0, 0);
    t = 0;
    while (!(bus.bc_handshake && run_len == 5)) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 100) begin
        check("mid_rst_timeout", 64'(run_len), 5);
        wrap_up();
      end
    end
    mon_en = 1'b0;
    nreset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_bc_handshake", bus.bc_handshake, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bc_data", bus.bc_data, 0);
    nreset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_s_ready", bus.s_ready, 1);
    mon_reset();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rand_record(r1);
    b0 = bursts;
    push_record(r1, 1'b0, 0);
    wait_bursts(b0 + 1, "post_rst_timeout");

    // Randomized traffic with random frame ends and core-ready drops
    rr_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rand_record(r0);
      push_record(r0, $urandom_range(4, 0) == 0, 3);
    end
    rr_en       = 1'b0;
    cores_ready = '1;
    t = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 3000) break;
    end
    check("drain_empty", 64'(exp_q.size()), 0);
    check("drain_busy", busy, 0);

    wrap_up();
  end

endmodule
